// File: rtl/fft_stage_reorder_buf.sv
// fft_stage_reorder_buf: single-frame buffer re-emitting natural-order samples in butterfly-pair order for a chosen FFT stage.
// Optional bit-reversed drain order with FFT_REORDER_BITREV_EN (adds bitrev_mode input).
module fft_stage_reorder_buf #(
    parameter int SAMPLES = 8,
    parameter int WIDTH = 16,
    localparam int LOG2N = $clog2(SAMPLES),
    localparam int IW = LOG2N
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IW-1:0]    stage_num,
`ifdef FFT_REORDER_BITREV_EN
    input  logic             bitrev_mode,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IW-1:0]    out_index,
    output logic             out_last,
    output logic             busy,
    output logic             stage_err
);
    if (SAMPLES < 2 || (SAMPLES & (SAMPLES - 1)) != 0) begin : g_bad_samples
        $error("SAMPLES must be a power of two >= 2");
    end

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
    localparam logic [IW-1:0] MAX_S = IW'(LOG2N - 1);
    localparam logic [IW-1:0] LAST = IW'(SAMPLES - 1);

    function automatic logic [IW-1:0] pair_idx(input logic [IW-1:0] p, input logic [IW-1:0] s);
        logic [IW-1:0] pair, half, j, i;
        pair = p >> 1;
        half = IW'(1) << s;
        j = pair & (half - IW'(1));
        i = pair >> s;
        return (i << (s + 1)) | j | (p[0] ? half : '0);
    endfunction

    state_t state, state_next;
    logic [WIDTH-1:0] mem [SAMPLES];
    logic [IW-1:0] wr_ptr, rd_ptr, rd_sel, idx_sel, stage_q, stage_c;
    logic first, accept, load_done, hs, too_big;

    assign in_ready = (state == IDLE) || (state == LOAD);
    assign busy = (state == LOAD) || (state == DRAIN);
    assign first = (state == IDLE) && in_valid;
    assign accept = in_valid && in_ready;
    assign load_done = (state == LOAD) && in_valid && (wr_ptr == LAST);
    assign hs = out_valid && out_ready;
    assign too_big = stage_num > MAX_S;
    assign stage_c = too_big ? MAX_S : stage_num;
    // The first drain position is always index 0, which was written long before the frame's last write.
    assign rd_sel = load_done ? '0 : rd_ptr + IW'(1);

`ifdef FFT_REORDER_BITREV_EN
    logic bitrev_q;
    function automatic logic [IW-1:0] bit_rev(input logic [IW-1:0] p);
        logic [IW-1:0] r;
        for (int b = 0; b < IW; b++) r[b] = p[IW-1-b];
        return r;
    endfunction
    assign idx_sel = bitrev_q ? bit_rev(rd_sel) : pair_idx(rd_sel, stage_q);
`else
    assign idx_sel = pair_idx(rd_sel, stage_q);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        state_next = first ? LOAD : load_done ? DRAIN : (hs && out_last) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            stage_q <= '0;
            stage_err <= 1'b0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_index <= '0;
            out_last <= 1'b0;
`ifdef FFT_REORDER_BITREV_EN
            bitrev_q <= 1'b0;
`endif
        end else begin
            if (first) stage_q <= stage_c;
`ifdef FFT_REORDER_BITREV_EN
            if (first) bitrev_q <= bitrev_mode;
            stage_err <= first && too_big && !bitrev_mode;
`else
            stage_err <= first && too_big;
`endif
            if (accept) wr_ptr <= wr_ptr + IW'(1);
            if (load_done || (hs && !out_last)) begin
                rd_ptr <= rd_sel;
                out_valid <= 1'b1;
                out_data <= mem[idx_sel];
                out_index <= idx_sel;
                out_last <= rd_sel == LAST;
            end else if (hs) begin
                rd_ptr <= '0;
                out_valid <= 1'b0;
                out_last <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fft_stage_reorder_buf.sv
// tb_fft_stage_reorder_buf: randomized frames checked against an arithmetic model of the butterfly-pair order.
module tb_fft_stage_reorder_buf;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [2:0] stage_num = '0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [15:0] in_data = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [15:0] out_data;
    logic [2:0] out_index;
    logic out_last;
    logic busy;
    logic stage_err;
    int checks = 0;
    int errors = 0;
`ifdef FFT_REORDER_BITREV_EN
    logic bitrev_mode = 1'b0;
`endif

    fft_stage_reorder_buf #(.SAMPLES(8), .WIDTH(16)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .stage_num(stage_num),
`ifdef FFT_REORDER_BITREV_EN
        .bitrev_mode(bitrev_mode),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_index(out_index),
        .out_last(out_last),
        .busy(busy),
        .stage_err(stage_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference order: output position p pairs index l+j with l+j+2^s.
    function automatic int model_idx(input int p, input int s, input bit br);
        int pair, j, i, r;
        if (br) begin
            r = 0;
            for (int b = 0; b < 3; b++) if (p & (1 << b)) r += 1 << (2 - b);
            return r;
        end
        pair = p / 2;
        j = pair % (2 ** s);
        i = pair / (2 ** s);
        return i * 2 ** (s + 1) + j + (p % 2) * 2 ** s;
    endfunction

    // rdy_mode: 0 always ready, 1 pattern 1,0,0,..., 2 random. abort_at<8 resets mid-drain.
    task automatic run_frame(input int s, input int base, input int gap_pct, input int rdy_mode,
                             input int abort_at, input bit br);
        logic [15:0] frame [8];
        int exp_idx [8];
        int es, p, cyc;
        es = (s > 2) ? 2 : s;
        for (int k = 0; k < 8; k++) begin
            frame[k] = (base >= 0) ? 16'(base + k) : 16'($urandom);
            exp_idx[k] = model_idx(k, es, br);
        end
        for (int k = 0; k < 8; k++) begin
            while (k > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                stage_num = 3'($urandom_range(7));
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data = frame[k];
            stage_num = (k == 0) ? 3'(s) : 3'($urandom_range(7));
`ifdef FFT_REORDER_BITREV_EN
            bitrev_mode = (k == 0) ? br : 1'($urandom_range(1));
`endif
            check("in_ready_load", in_ready, 1);
            check("out_valid_load", out_valid, 0);
            @(negedge clk);
            check("stage_err", stage_err, (k == 0) ? 32'((s > 2) && !br) : 0);
            check("busy_load", busy, 1);
        end
        in_valid = 1'b0;
        check("out_valid_first", out_valid, 1);
        check("in_ready_drain", in_ready, 0);
        p = 0;
        cyc = 0;
        while (p < 8 && cyc < 200) begin
            if (p == abort_at) begin
                reset_n = 1'b0;
                #1;
                check("rst_out_valid", out_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_out_last", out_last, 0);
                @(negedge clk);
                reset_n = 1'b1;
                out_ready = 1'b0;
                check("rst_in_ready", in_ready, 1);
                return;
            end
            out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(1));
            check("out_valid", out_valid, 1);
            check("out_index", out_index, exp_idx[p]);
            check("out_data", out_data, frame[exp_idx[p]]);
            check("out_last", out_last, p == 7);
            @(negedge clk);
            if (out_ready) p++;
            cyc++;
        end
        out_ready = 1'b0;
        if (p < 8) check("drain_timeout", p, 8);
        check("out_valid_done", out_valid, 0);
        check("busy_done", busy, 0);
        check("in_ready_done", in_ready, 1);
    endtask

    initial begin
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_stage_err", stage_err, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_index", out_index, 0);
        check("reset_out_last", out_last, 0);
        @(negedge clk);
        reset_n = 1'b1;
        check("reset_in_ready", in_ready, 1);
        run_frame(0, 10, 0, 0, 8, 1'b0);
        run_frame(1, -1, 0, 0, 8, 1'b0);
        run_frame(2, -1, 0, 0, 8, 1'b0);
        run_frame(2, -1, 30, 1, 8, 1'b0);
        run_frame(5, -1, 20, 2, 8, 1'b0);
        run_frame(2, -1, 0, 0, 3, 1'b0);
        run_frame(1, -1, 10, 2, 8, 1'b0);
        for (int n = 0; n < 12; n++)
            run_frame($urandom_range(7), -1, $urandom_range(40), $urandom_range(2), 8, 1'b0);
`ifdef FFT_REORDER_BITREV_EN
        run_frame(6, -1, 10, 2, 8, 1'b1);
        run_frame(1, -1, 0, 0, 8, 1'b0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
